bcd_score_counter: RTL and testbench
====================================

Name: bcd_score_counter

Overview:
Parametrised multi-digit BCD counter. It is the next generation of the single-decade game counter and drives the floor/score display in the game datapath. Features:
- cascaded decades
- up/down counting
- synchronous load and clear
- wrap or saturate mode at the range limits
- a registered wrap pulse and a sticky overflow flag for the game controller

Parameters:
DIGITS, 3, number of BCD decades; range 0 .. 10^DIGITS-1.
SATURATE, 0, 0 = wrap at the limits; 1 = hold at the limit.

Ports:
cp  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
en  input  1  count enable.
pause  input  1  freezes the count and flags (load/clr still honoured).
endgame  input  1  freezes the count and flags (load/clr still honoured).
up_dn  input  1  1 = increment, 0 = decrement.
clr  input  1  synchronous clear to zero.
load  input  1  synchronous load of load_val.
load_val  input  4*DIGITS  BCD load value; digit i is bits [4i+3:4i].
Q  output  4*DIGITS  BCD count; digit 0 is least significant.
wrap  output  1  one-cycle pulse, coincident with the wrapped Q value.
ovf  output  1  sticky: a limit was crossed (wrap mode) or hit with a blocked step (saturate mode).
at_limit  output  1  combinational; Q == all-9s when up_dn=1, Q == 0 when up_dn=0.

Behaviour:
- Single clock domain: cp. Reset is asynchronous and active-high on rst. All state updates on posedge cp.
- Reset values: Q=0, wrap=0, ovf=0.
- Per-edge priority: rst > clr > load > hold > step.
- clr: Q=0, ovf=0, wrap=0.
- load: Q=load_val, ovf=0, wrap=0. Any load digit greater than 9 is clamped to 9 per digit.
- hold: applies when en=0, pause=1 or endgame=1. Q and ovf keep their values; wrap=0.
- step: applies when en=1, pause=0 and endgame=0. Q moves by +1 (up_dn=1) or -1 (up_dn=0) in BCD.
- Ripple carry/borrow between decades:
  - digit i changes only when every lower digit is at 9 (up) or at 0 (down)
  - up: a digit at 9 goes to 0; down: a digit at 0 goes to 9
  - the whole count updates in one cycle; latency is 1 edge
- Upper limit, up: Q all-9s with a step.
  - SATURATE=0: Q goes to 0, wrap=1 for that cycle, ovf sets.
  - SATURATE=1: Q stays at all-9s, wrap=0, ovf sets.
- Lower limit, down: Q=0 with a step.
  - SATURATE=0: Q goes to all-9s, wrap=1, ovf sets.
  - SATURATE=1: Q stays at 0, ovf sets.
- wrap is registered. It is high for exactly one cycle after the wrapping edge and low otherwise.
- up_dn may change on any cycle. The edge uses the value sampled at that edge.
- rst asserted mid-count zeroes all outputs immediately, without waiting for a clock edge. After release, stepping resumes on the first edge with rst low.
- Q digits never hold values greater than 9.

Decomposition:
- Shared package constants:
  - BCD_MAX = 4'd9
  - BCD_MIN = 4'd0
  - DIGIT_W = 4
- Sub-module bcd_digit: one decade.
  - Inputs: step-in (carry/borrow), up_dn, clr, load, load digit.
  - Outputs: 4-bit digit and a step-out that is high when the digit is at its terminal value (9 up / 0 down) and step-in is high.
- Top level:
  - instantiates DIGITS copies of bcd_digit in a generate loop
  - holds the limit/saturate decision, wrap and ovf
  - feeds gated step-in to digit 0

Test Plan:
1. Reset and simple count, DIGITS=3, SATURATE=0. Pulse rst high mid-cycle → Q=000 asynchronously. Then en=1, up_dn=1 for 12 edges → Q=012; wrap=0, ovf=0.
2. Carry ripple and wrap. Load 998, count up 2 edges → Q=999 then 000, wrap high exactly on the 000 cycle, ovf=1. One more edge → Q=001, wrap=0, ovf stays 1.
3. Down with borrow and saturate, SATURATE=1. Load 100, up_dn=0, 2 edges → 099, 098. Load 001, 3 edges → 000, 000, 000; ovf=1 from the second edge; wrap never asserts.
4. Hold conditions. Q=045 with en=1; pause=1 for 5 edges → Q=045. pause=0, endgame=1 for 5 edges → Q=045. endgame=0 → 046 on the next edge. load during pause → Q takes load_val.
5. Priority and clamp. clr=1 and load=1 on the same edge with load_val=0xF3A → Q=000. Next edge load=1 only → Q=939 (per-digit clamp), ovf cleared.
6. Direction change at the limit, SATURATE=0. Q=999 with up_dn=0 → 998. Flip to up_dn=1 → 999. Next edge → 000 with wrap=1; at_limit tracks up_dn combinationally.

Source files
------------

// File: rtl/bcd_score_counter_pkg.sv
// bcd_score_counter_pkg: shared BCD digit constants and load-value clamping.
package bcd_score_counter_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction
endpackage

// File: rtl/bcd_score_counter_digit.sv
// bcd_digit: one BCD decade with clear/load/step and a ripple step-out at its terminal value.
module bcd_digit
    import bcd_score_counter_pkg::*;
(
    input  logic               cp,
    input  logic               rst,
    input  logic               step_i,
    input  logic               up_dn_i,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_d_i,
    output logic [DIGIT_W-1:0] q_o,
    output logic               step_o
);
    logic [DIGIT_W-1:0] q_q, q_d;

    always_comb begin
        q_d = clr_i    ? BCD_MIN :
              load_i   ? clamp_digit(load_d_i) :
              !step_i  ? q_q :
              up_dn_i  ? ((q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1) :
                         ((q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1);
    end

    always_ff @(posedge cp or posedge rst) begin
        if (rst) q_q <= BCD_MIN;
        else     q_q <= q_d;
    end

    assign q_o    = q_q;
    assign step_o = step_i && (q_q == (up_dn_i ? BCD_MAX : BCD_MIN));
endmodule

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: cascaded up/down BCD counter with load/clear, wrap or saturate
// at the range limits, a registered wrap pulse and a sticky overflow flag.
module bcd_score_counter
    import bcd_score_counter_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic                        cp,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        pause,
    input  logic                        endgame,
    input  logic                        up_dn,
    input  logic                        clr,
    input  logic                        load,
    input  logic [DIGIT_W*DIGITS-1:0]   load_val,
    output logic [DIGIT_W*DIGITS-1:0]   Q,
    output logic                        wrap,
    output logic                        ovf,
    output logic                        at_limit
);
    logic [DIGITS:0] carry;
    logic            step_go;
    logic            wrap_q, wrap_d;
    logic            ovf_q, ovf_d;

    assign step_go  = en && !pause && !endgame;
    assign at_limit = (Q == (up_dn ? {DIGITS{BCD_MAX}} : {DIGITS{BCD_MIN}}));
    // In saturate mode a step at the limit is swallowed before it reaches the chain.
    assign carry[0] = step_go && !(SATURATE && at_limit);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .cp       (cp),
            .rst      (rst),
            .step_i   (carry[i]),
            .up_dn_i  (up_dn),
            .clr_i    (clr),
            .load_i   (load),
            .load_d_i (load_val[DIGIT_W*i +: DIGIT_W]),
            .q_o      (Q[DIGIT_W*i +: DIGIT_W]),
            .step_o   (carry[i+1])
        );
    end

    // A step leaving the top decade means the whole count rolled over.
    always_comb begin
        wrap_d = !clr && !load && carry[DIGITS];
        ovf_d  = (clr || load) ? 1'b0 : (ovf_q || (step_go && at_limit));
    end

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign wrap = wrap_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_bcd_score_counter.sv
// tb_bcd_score_counter: scoreboard bench driving a wrap-mode and a saturate-mode counter in parallel.
module tb_bcd_score_counter;
    localparam int D    = 3;
    localparam int W    = 4 * D;
    localparam int MAXV = 999;

    logic cp = 1'b0;
    logic rst, en, pause, endgame, up_dn, clr, load;
    logic [W-1:0] load_val;
    logic [W-1:0] q_w, q_s;
    logic wrap_w, wrap_s, ovf_w, ovf_s, al_w, al_s;

    typedef struct packed {
        logic [1:0][W-1:0] q;
        logic [1:0]        w;
        logic [1:0]        o;
        logic [1:0]        a;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   mv[2];
    bit   mo[2];
    int   checks = 0;
    int   fails  = 0;

    always #5 cp = ~cp;

    bcd_score_counter #(.DIGITS(D), .SATURATE(1'b0)) u_wrap (
        .cp(cp), .rst(rst), .en(en), .pause(pause), .endgame(endgame), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .Q(q_w), .wrap(wrap_w), .ovf(ovf_w), .at_limit(al_w)
    );

    bcd_score_counter #(.DIGITS(D), .SATURATE(1'b1)) u_sat (
        .cp(cp), .rst(rst), .en(en), .pause(pause), .endgame(endgame), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .Q(q_s), .wrap(wrap_s), .ovf(ovf_s), .at_limit(al_s)
    );

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int p;
        p = 1;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [W-1:0] lv);
        int v, p, d;
        v = 0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge: apply inputs, advance the reference model, queue the expectation.
    task automatic drive(input bit e, input bit p, input bit g, input bit u,
                         input bit c, input bit l, input logic [W-1:0] lv);
        exp_t x;
        bit w;
        en = e; pause = p; endgame = g; up_dn = u; clr = c; load = l; load_val = lv;
        for (int k = 0; k < 2; k++) begin
            w = 1'b0;
            if (c) begin
                mv[k] = 0; mo[k] = 1'b0;
            end else if (l) begin
                mv[k] = from_load(lv); mo[k] = 1'b0;
            end else if (e && !p && !g) begin
                if (u) begin
                    if (mv[k] == MAXV) begin
                        mo[k] = 1'b1;
                        if (k == 0) begin mv[k] = 0; w = 1'b1; end
                    end else mv[k] = mv[k] + 1;
                end else begin
                    if (mv[k] == 0) begin
                        mo[k] = 1'b1;
                        if (k == 0) begin mv[k] = MAXV; w = 1'b1; end
                    end else mv[k] = mv[k] - 1;
                end
            end
            x.q[k] = to_bcd(mv[k]);
            x.w[k] = w;
            x.o[k] = mo[k];
            x.a[k] = u ? (mv[k] == MAXV) : (mv[k] == 0);
        end
        sb.push_back(x);
    endtask

    task automatic cyc(input bit e, input bit p, input bit g, input bit u,
                       input bit c, input bit l, input logic [W-1:0] lv);
        @(negedge cp);
        drive(e, p, g, u, c, l, lv);
        @(posedge cp);
    endtask

    task automatic step(input bit u, input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, u, 0, 0, '0);
    endtask

    // Called just after a posedge: assert rst mid-cycle, expect immediate zeros, then count up on release.
    task automatic rst_pulse();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_q_w", 32'(q_w), 32'd0);
        chk("async_rst_q_s", 32'(q_s), 32'd0);
        chk("async_rst_wrap", 32'({wrap_w, wrap_s}), 32'd0);
        chk("async_rst_ovf", 32'({ovf_w, ovf_s}), 32'd0);
        chk("async_rst_at_limit_w", 32'(al_w), 32'(!up_dn));
        mv[0] = 0; mv[1] = 0; mo[0] = 1'b0; mo[1] = 1'b0;
        @(negedge cp);
        rst = 1'b0;
        drive(1, 0, 0, 1, 0, 0, '0);
        @(posedge cp);
    endtask

    always @(posedge cp) begin
        #1;
        if (!rst && sb.size() > 0) begin
            mx = sb.pop_front();
            chk("q_wrapmode", 32'(q_w), 32'(mx.q[0]));
            chk("q_satmode", 32'(q_s), 32'(mx.q[1]));
            chk("wrap_wrapmode", 32'(wrap_w), 32'(mx.w[0]));
            chk("wrap_satmode", 32'(wrap_s), 32'(mx.w[1]));
            chk("ovf_wrapmode", 32'(ovf_w), 32'(mx.o[0]));
            chk("ovf_satmode", 32'(ovf_s), 32'(mx.o[1]));
            chk("at_limit_wrapmode", 32'(al_w), 32'(mx.a[0]));
            chk("at_limit_satmode", 32'(al_s), 32'(mx.a[1]));
        end
    end

    initial begin
        logic [W-1:0] lv;
        int r;
        rst = 1'b1; en = 0; pause = 0; endgame = 0; up_dn = 1; clr = 0; load = 0; load_val = '0;
        mv[0] = 0; mv[1] = 0; mo[0] = 1'b0; mo[1] = 1'b0;
        #2;
        chk("reset_q", 32'({q_w, q_s}), 32'd0);
        chk("reset_flags", 32'({wrap_w, wrap_s, ovf_w, ovf_s}), 32'd0);
        @(negedge cp);
        rst = 1'b0;
        @(posedge cp);
        // reset mid-count, then reach 012
        step(1, 4);
        rst_pulse();
        step(1, 11);
        // carry ripple and wrap
        cyc(0, 0, 0, 1, 0, 1, 12'h998);
        step(1, 3);
        // borrow and saturate at zero
        cyc(0, 0, 0, 0, 0, 1, 12'h100);
        step(0, 2);
        cyc(0, 0, 0, 0, 0, 1, 12'h001);
        step(0, 3);
        // hold conditions
        cyc(0, 0, 0, 1, 0, 1, 12'h044);
        step(1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1, 0, 0, '0);
        step(1, 1);
        cyc(1, 1, 0, 1, 0, 1, 12'h321);
        // clear beats load, then per-digit clamp
        cyc(1, 0, 0, 1, 1, 1, 12'hF3A);
        cyc(1, 0, 0, 1, 0, 1, 12'hF3A);
        // direction change at the limit
        cyc(0, 0, 0, 1, 0, 1, 12'h999);
        step(0, 1);
        step(1, 2);
        // randomized traffic biased toward the limits
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) rst_pulse();
            else begin
                case ($urandom_range(0, 4))
                    0: lv = 12'h999;
                    1: lv = 12'h000;
                    2: lv = 12'h998;
                    3: lv = 12'h001;
                    default: lv = W'($urandom);
                endcase
                cyc($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                    1'($urandom), $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0, lv);
            end
        end
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge cp);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
